// File: rtl/seg_disp_pkg.sv
// Shared constants, types and helpers for the multiplexed 7-segment scanner.
// Latency: none (declarations only).
// Backpressure: not applicable.
package seg_disp_pkg;

  // Blank pattern. Segments are active-low, so every bit set means "off".
  // Users slice this down to their own pattern width.
  localparam logic [63:0] SEG_BLANK = '1;

  // Scan phase within one digit slot.
  typedef enum logic [0:0] {
    ST_BLANK = 1'b0,
    ST_ON    = 1'b1
  } scan_state_t;

  // LSB position of digit 'digit' inside a flat vector of seg_w-bit patterns.
  function automatic int seg_lsb(input int digit, input int seg_w);
    return digit * seg_w;
  endfunction

endpackage

// File: rtl/seg_frame_buffer.sv
// Double buffer for digit patterns: a one-entry pending stage fed by a valid/ready
// handshake, copied into the displayed (active) frame only at frame wraps.
// Latency: 1 cycle into pending; pending reaches active on the next frame wrap.
// Backpressure: upd_ready is low while pending holds a frame; it rises after the draining wrap.
//
// Ports:
//   clk, rst_n  clock and asynchronous active-low reset
//   seg_in      N_DIGITS*SEG_W new frame, captured on upd_valid && upd_ready
//   upd_valid   seg_in holds a new frame
//   upd_ready   pending stage is empty (registered)
//   wrap        one-cycle strobe on the last cycle of a frame
//   active      frame currently being displayed
module seg_frame_buffer
  import seg_disp_pkg::*;
#(
  parameter int N_DIGITS = 8,
  parameter int SEG_W    = 8
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [N_DIGITS*SEG_W-1:0] seg_in,
  input  logic                      upd_valid,
  output logic                      upd_ready,
  input  logic                      wrap,
  output logic [N_DIGITS*SEG_W-1:0] active
);

  logic [N_DIGITS*SEG_W-1:0] pending;
  logic                      pending_full;
  logic                      pending_full_nxt;
  logic                      handshake;

  assign handshake = upd_valid && upd_ready;

  // A handshake can only happen with pending empty, so it never races a drain:
  // a capture on a wrap cycle simply waits for the following wrap.
  always_comb begin
    pending_full_nxt = pending_full;
    if (handshake) begin
      pending_full_nxt = 1'b1;
    end else if (wrap) begin
      pending_full_nxt = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending      <= '1;
      pending_full <= 1'b0;
      upd_ready    <= 1'b1;
      active       <= '1;
    end else begin
      if (handshake) begin
        pending <= seg_in;
      end
      if (wrap && pending_full) begin
        active <= pending;
      end
      pending_full <= pending_full_nxt;
      upd_ready    <= !pending_full_nxt;
    end
  end

endmodule

// File: rtl/seven_segment_n_scanner.sv
// N-digit multiplexed 7-segment scanner with per-digit enable, blink, PWM brightness,
// anti-ghost blanking and a frame-synchronous double buffer.
// Latency: outputs are registered, 1 cycle behind the scan counters; updates show within one frame + 1.
// Backpressure: upd_ready drops while a frame is pending and recovers after the next frame wrap.
//
// Ports:
//   clk, rst_n  clock and asynchronous active-low reset
//   seg_in      active-low patterns, digit d at [d*SEG_W +: SEG_W]
//   upd_valid / upd_ready  frame update handshake
//   digit_en    per-digit light enable
//   blink_mask  per-digit blank during blink phase 1
//   brightness  PWM duty (0 dark, all-ones always on)
//   seg_out     registered active-low cathodes
//   seg_sel     registered active-low anodes, one-hot or none
//   frame_tick  one-cycle pulse aligned with the first output cycle of digit 0
module seven_segment_n_scanner
  import seg_disp_pkg::*;
#(
  parameter int N_DIGITS   = 8,
  parameter int SEG_W      = 8,
  parameter int DWELL_CYC  = 16384,
  parameter int BLANK_CYC  = 64,
  parameter int BRIGHT_W   = 4,
  parameter int BLINK_LOG2 = 24
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [N_DIGITS*SEG_W-1:0] seg_in,
  input  logic                      upd_valid,
  output logic                      upd_ready,
  input  logic [N_DIGITS-1:0]       digit_en,
  input  logic [N_DIGITS-1:0]       blink_mask,
  input  logic [BRIGHT_W-1:0]       brightness,
  output logic [SEG_W-1:0]          seg_out,
  output logic [N_DIGITS-1:0]       seg_sel,
  output logic                      frame_tick
);

  localparam int SLOT_W = (DWELL_CYC > 1) ? $clog2(DWELL_CYC) : 1;
  localparam int DIG_W  = $clog2(N_DIGITS);

  localparam logic [SLOT_W-1:0] SLOT_LAST = SLOT_W'(DWELL_CYC - 1);
  localparam logic [SLOT_W-1:0] BLANK_LIM = SLOT_W'(BLANK_CYC);
  localparam logic [DIG_W-1:0]  DIG_LAST  = DIG_W'(N_DIGITS - 1);

  logic [SLOT_W-1:0]     slot_cnt;
  logic [SLOT_W-1:0]     slot_nxt;
  logic [DIG_W-1:0]      digit_idx;
  logic [BRIGHT_W-1:0]   pwm_cnt;
  logic [BLINK_LOG2-1:0] blink_cnt;
  scan_state_t           state;
  scan_state_t           state_nxt;

  logic                      slot_wrap;
  logic                      frame_wrap;
  logic                      tick_pre;
  logic                      pwm_on;
  logic                      blink_off;
  logic                      lit;
  logic [N_DIGITS*SEG_W-1:0] active;
  logic [SEG_W-1:0]          active_dig;

  seg_frame_buffer #(
    .N_DIGITS (N_DIGITS),
    .SEG_W    (SEG_W)
  ) u_frame_buffer (
    .clk       (clk),
    .rst_n     (rst_n),
    .seg_in    (seg_in),
    .upd_valid (upd_valid),
    .upd_ready (upd_ready),
    .wrap      (frame_wrap),
    .active    (active)
  );

  assign slot_wrap  = (slot_cnt == SLOT_LAST);
  assign frame_wrap = slot_wrap && (digit_idx == DIG_LAST);
  assign slot_nxt   = slot_wrap ? '0 : slot_cnt + SLOT_W'(1);

  // State is derived from the next slot count so it always matches slot_cnt
  // in the same cycle: ST_BLANK for the first BLANK_CYC cycles of every slot.
  assign state_nxt = (slot_nxt >= BLANK_LIM) ? ST_ON : ST_BLANK;

  assign pwm_on     = (&brightness) || (pwm_cnt < brightness);
  assign blink_off  = blink_mask[digit_idx] && blink_cnt[BLINK_LOG2-1];
  assign lit        = (state == ST_ON) && digit_en[digit_idx] && pwm_on && !blink_off;
  assign active_dig = active[seg_lsb(32'(digit_idx), SEG_W) +: SEG_W];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slot_cnt  <= '0;
      digit_idx <= '0;
      pwm_cnt   <= '0;
      blink_cnt <= '0;
      state     <= ST_BLANK;
    end else begin
      slot_cnt  <= slot_nxt;
      pwm_cnt   <= pwm_cnt + BRIGHT_W'(1);
      blink_cnt <= blink_cnt + BLINK_LOG2'(1);
      state     <= state_nxt;
      if (slot_wrap) begin
        digit_idx <= frame_wrap ? '0 : digit_idx + DIG_W'(1);
      end
    end
  end

  // Output stage. frame_tick takes two flops so it lines up with the output
  // registers (which show the counters one cycle late), not with the counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seg_out    <= SEG_BLANK[SEG_W-1:0];
      seg_sel    <= '1;
      tick_pre   <= 1'b0;
      frame_tick <= 1'b0;
    end else begin
      tick_pre   <= frame_wrap;
      frame_tick <= tick_pre;
      if (lit) begin
        seg_out <= active_dig;
        seg_sel <= ~(N_DIGITS'(1) << digit_idx);
      end else begin
        seg_out <= SEG_BLANK[SEG_W-1:0];
        seg_sel <= '1;
      end
    end
  end

endmodule
